fwft_fifo_param: RTL and testbench

Parametrised first-word-fall-through synchronous FIFO. It is the successor of the fixed 362-bit, 4-deep buffer used between pipeline stages.
- Adds a configurable data width and depth.
- Enforces full/empty protection in hardware.
- Adds occupancy count, almost-empty and almost-full thresholds, sticky overflow/underflow error flags, and a synchronous flush.
- Sits between producer and consumer stages of the core pipeline. The consumer sees head data on o_data whenever o_buf_empty is low.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_sdp_ram.sv | 34 +++
 rtl/fwft_fifo_param.sv | 134 +++++++++++++
 tb/tb_fwft_fifo_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FWFT FIFO.
//   DEFAULT_DATA_WIDTH / DEFAULT_DEPTH : defaults matching the legacy
//                                        362-bit, 4-deep stage buffer.
//   log2_ceil : constant function used to derive ADDR_WIDTH.
//   is_pow2   : depth legality check evaluated at elaboration time.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 362;
  localparam int DEFAULT_DEPTH      = 4;

  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Storage depth must be a power of two (pointer wrap relies on it) and
  // at least 2 so that ADDR_WIDTH is non-zero.
  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: registered write port, asynchronous read port.
// Asynchronous read lets the prefetch load the head register in the same
// cycle it advances the read pointer; maps onto distributed RAM.
//   i_clk    : write clock
//   i_w_en   : write strobe
//   i_w_addr : write address
//   i_w_data : write data
//   i_r_addr : read address
//   o_r_data : read data (combinational from i_r_addr)
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = log2_ceil(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_w_en,
  input  logic [ADDR_WIDTH-1:0] i_w_addr,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic [ADDR_WIDTH-1:0] i_r_addr,
  output logic [DATA_WIDTH-1:0] o_r_data
);

  // Contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_w_en) mem[i_w_addr] <= i_w_data;
  end

  assign o_r_data = mem[i_r_addr];

endmodule

// File: rtl/fwft_fifo_param.sv
// First-word-fall-through synchronous FIFO between core pipeline stages.
// Storage RAM of DEPTH entries plus one output (head) register, so the
// total capacity is DEPTH+1. The head entry is presented on o_data while
// o_buf_empty is low; i_r_en pops it.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_w_en, i_data      : write request and data
//   i_r_en              : pop head entry
//   i_flush             : synchronous clear of contents and error flags
//   i_clr_err           : clear sticky error flags
//   o_data              : head entry, zero when empty
//   o_buf_empty         : no valid head entry
//   o_buf_full          : RAM holds DEPTH entries
//   o_buf_almost_full   : RAM occupancy >= DEPTH-AF_MARGIN
//   o_buf_almost_empty  : total count <= AE_MARGIN
//   o_count             : RAM occupancy + head valid
//   o_overflow          : sticky, write attempted while full
//   o_underflow         : sticky, read attempted while empty
module fwft_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = log2_ceil(DEPTH),
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_w_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_r_en,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_buf_empty,
  output logic                  o_buf_full,
  output logic                  o_buf_almost_full,
  output logic                  o_buf_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  if (!is_pow2(DEPTH) || (ADDR_WIDTH != log2_ceil(DEPTH))) begin : g_bad_cfg
    $error("fwft_fifo_param: DEPTH must be a power of two >= 2 and ADDR_WIDTH = log2(DEPTH)");
  end

  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL   = (ADDR_WIDTH+1)'(AE_MARGIN);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   ram_occ;
  logic                  ram_empty;
  logic                  ram_full;
  logic                  wr_accept;
  logic                  prefetch;
  logic                  ovf_event;
  logic                  unf_event;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] head_data_p1;
  logic                  vld_p1;
  logic                  overflow;
  logic                  underflow;

  // Stage 0: RAM occupancy, acceptance and prefetch decisions.
  assign ram_occ   = wr_ptr - rd_ptr;
  assign ram_empty = (ram_occ == '0);
  assign ram_full  = (ram_occ == FULL_LEVEL);

  // Full is judged on the RAM alone: a prefetch in the same cycle does not
  // make room for a write presented in that cycle.
  assign wr_accept = i_w_en && !ram_full && !i_flush;
  assign prefetch  = !ram_empty && (!vld_p1 || i_r_en) && !i_flush;
  assign ovf_event = i_w_en && ram_full;
  assign unf_event = i_r_en && !vld_p1;

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk    (i_clk),
    .i_w_en   (wr_accept),
    .i_w_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .i_w_data (i_data),
    .i_r_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .o_r_data (ram_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      vld_p1    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (i_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      vld_p1    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (prefetch) begin
        rd_ptr <= rd_ptr + 1'b1;
        vld_p1 <= 1'b1;
      end else if (i_r_en) begin
        vld_p1 <= 1'b0;
      end
      // A new error event wins over a same-cycle clear.
      overflow  <= ovf_event || (overflow  && !i_clr_err);
      underflow <= unf_event || (underflow && !i_clr_err);
    end
  end

  // Stage 1: head register; qualified by vld_p1 so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (prefetch) head_data_p1 <= ram_rd_data;
  end

  assign o_data             = vld_p1 ? head_data_p1 : '0;
  assign o_buf_empty        = !vld_p1;
  assign o_buf_full         = ram_full;
  assign o_buf_almost_full  = (ram_occ >= AF_LEVEL);
  assign o_count            = ram_occ + {{ADDR_WIDTH{1'b0}}, vld_p1};
  assign o_buf_almost_empty = (o_count <= AE_LEVEL);
  assign o_overflow         = overflow;
  assign o_underflow        = underflow;

endmodule

// File: tb/tb_fwft_fifo_param.sv
module tb_fwft_fifo_param;

  localparam int DW    = 362;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int AF    = 1;
  localparam int AE    = 1;

  logic          clk;
  logic          rst_n;
  logic          w_en;
  logic [DW-1:0] wdata;
  logic          r_en;
  logic          flush;
  logic          clr_err;
  logic [DW-1:0] o_data;
  logic          o_buf_empty;
  logic          o_buf_full;
  logic          o_buf_almost_full;
  logic          o_buf_almost_empty;
  logic [AW:0]   o_count;
  logic          o_overflow;
  logic          o_underflow;

  fwft_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .AF_MARGIN  (AF),
    .AE_MARGIN  (AE)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_w_en             (w_en),
    .i_data             (wdata),
    .i_r_en             (r_en),
    .i_flush            (flush),
    .i_clr_err          (clr_err),
    .o_data             (o_data),
    .o_buf_empty        (o_buf_empty),
    .o_buf_full         (o_buf_full),
    .o_buf_almost_full  (o_buf_almost_full),
    .o_buf_almost_empty (o_buf_almost_empty),
    .o_count            (o_count),
    .o_overflow         (o_overflow),
    .o_underflow        (o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: total entry count, whether the head is visible, sticky
  // flags, and a scoreboard queue holding every stored entry in order.
  int            m_size;
  bit            m_hv;
  bit            m_ovf;
  bit            m_unf;
  logic [DW-1:0] sb[$];

  int  checks;
  int  passed;
  bit  done;

  task automatic model_reset();
    m_size = 0;
    m_hv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    sb.delete();
  endtask

  // Advance the model across one rising edge using the inputs held during
  // the cycle that just ended. Entries written at this edge are not visible
  // at the head until the next edge.
  task automatic model_step();
    int  ram;
    bit  full;
    bit  acc;
    bit  pop;
    int  old_n;
    if (!rst_n) return;
    ram  = m_size - int'(m_hv);
    full = (ram == DEPTH);
    if (flush) begin
      model_reset();
    end else begin
      acc    = w_en && !full;
      pop    = r_en && m_hv;
      m_ovf  = (w_en && full) || (m_ovf && !clr_err);
      m_unf  = (r_en && !m_hv) || (m_unf && !clr_err);
      old_n  = m_size - int'(pop);
      m_hv   = (old_n > 0);
      m_size = old_n + int'(acc);
      if (acc) sb.push_back(wdata);
    end
  endtask

  task automatic cyc(input bit w, input bit r, input bit f, input bit c,
                     input logic [DW-1:0] d);
    @(posedge clk);
    model_step();
    #1;
    w_en    = w;
    r_en    = r;
    flush   = f;
    clr_err = c;
    wdata   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic assert_reset_mid();
    @(posedge clk);
    model_step();
    #1;
    rst_n   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW; i += 32) v = (v << 32) | DW'($urandom);
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Monitor: compare every status output against the model each cycle and
  // pop the scoreboard whenever the DUT hands over its head entry.
  initial begin
    logic [DW-1:0] exp_head;
    int            ram;
    forever begin
      @(negedge clk);
      if (!done) begin
        ram      = m_size - int'(m_hv);
        exp_head = (m_hv && sb.size() > 0) ? sb[0] : '0;
        chk("empty",        DW'(o_buf_empty),        DW'(!m_hv));
        chk("full",         DW'(o_buf_full),         DW'(ram == DEPTH));
        chk("almost_full",  DW'(o_buf_almost_full),  DW'(ram >= DEPTH - AF));
        chk("almost_empty", DW'(o_buf_almost_empty), DW'(m_size <= AE));
        chk("count",        DW'(o_count),            DW'(m_size));
        chk("overflow",     DW'(o_overflow),         DW'(m_ovf));
        chk("underflow",    DW'(o_underflow),        DW'(m_unf));
        chk("head_data",    o_data,                  exp_head);
        if (rst_n && r_en && !flush && !o_buf_empty) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL pop_data at %0t: got %0h expected no entry", $time, o_data);
          end else begin
            exp_head = sb.pop_front();
            chk("pop_data", o_data, exp_head);
          end
        end
      end
    end
  end

  initial begin
    checks  = 0;
    passed  = 0;
    done    = 1'b0;
    rst_n   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
    wdata   = '0;
    model_reset();
    idle(2);
    release_reset();
    idle(3);

    // Single entry: visible one edge after the write, popped by one read.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(32'hA5));
    idle(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(2);

    // Fill to DEPTH+1, overflow attempt, then drain in order plus one
    // extra read to produce an underflow.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, (rand_data() << 8) | DW'(i));
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(32'hDEAD));
    idle(1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(2);

    // Error flag clearing, and a new event beating a same-cycle clear.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(1);

    // Steady-state simultaneous read and write at count 2.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(100));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(101));
    idle(1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, DW'(102 + i));
    idle(1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);

    // Flush with a concurrent write at count 3, after raising overflow.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, rand_data());
    cyc(1'b1, 1'b0, 1'b0, 1'b0, rand_data());
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, rand_data());
    idle(2);

    // Reset dropped in the middle of a write burst.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, rand_data());
    idle(1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, rand_data());
    assert_reset_mid();
    idle(1);
    release_reset();
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 5, rand_data());
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(2);

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
